// File: rtl/hack_cpu_mc.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | hack_cpu_mc : parametrised multicycle Hack CPU, req/ack imem and dmem       |
// | Optional: HACK_CPU_INSTRET_EN adds a 32-bit retired-instruction counter.    |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
module hack_cpu_mc #(
  parameter int          DW       = 16,
  parameter int          AW       = 15,
  parameter int unsigned RESET_PC = 0
) (
  input  logic          clk,
  input  logic          rstn,
  output logic          imem_req,
  output logic [AW-1:0] imem_addr,
  input  logic          imem_ack,
  input  logic [15:0]   imem_rdata,
  output logic          dmem_req,
  output logic          dmem_we,
  output logic [AW-1:0] dmem_addr,
  output logic [DW-1:0] dmem_wdata,
  input  logic          dmem_ack,
  input  logic [DW-1:0] dmem_rdata,
  output logic [AW-1:0] pc,
  output logic          retire
`ifdef HACK_CPU_INSTRET_EN
  ,
  output logic [31:0]   instret
`endif
);

  generate
    if (DW < 16 || AW > DW) begin : g_bad_params
      $error("hack_cpu_mc: requires DW >= 16 and AW <= DW");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_DLOAD = 2'd1,
    S_EXEC  = 2'd2,
    S_STORE = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] pc_q, pc_d;
  logic [DW-1:0] a_q, a_d;
  logic [DW-1:0] d_q, d_d;
  logic [15:0]   ir_q, ir_d;
  logic [DW-1:0] mr_q, mr_d;
  logic [AW-1:0] wa_q, wa_d;
  logic [DW-1:0] wd_q, wd_d;

  logic          imem_req_w;
  logic          dmem_req_w;
  logic          dmem_we_w;
  logic [AW-1:0] dmem_addr_w;
  logic          retire_w;

  logic [DW-1:0] alu_x;
  logic [DW-1:0] alu_y;
  logic [DW-1:0] alu_out;
  logic          alu_zr;
  logic          alu_ng;
  logic          jump;
  logic [AW-1:0] pc_inc;
  logic [DW-1:0] a_imm;

  // Hack ALU: control bits zx nx zy ny f no sit in IR[11:6]
  always_comb begin
    alu_x = d_q;
    alu_y = ir_q[12] ? mr_q : a_q;
    if (ir_q[11]) alu_x = '0;
    if (ir_q[10]) alu_x = ~alu_x;
    if (ir_q[9])  alu_y = '0;
    if (ir_q[8])  alu_y = ~alu_y;
    alu_out = ir_q[7] ? (alu_x + alu_y) : (alu_x & alu_y);
    if (ir_q[6])  alu_out = ~alu_out;
  end

  assign alu_zr = (alu_out == '0);
  assign alu_ng = alu_out[DW-1];
  assign jump   = (ir_q[2] & alu_ng) | (ir_q[1] & alu_zr) | (ir_q[0] & ~alu_ng & ~alu_zr);
  assign pc_inc = pc_q + AW'(1);
  assign a_imm  = {{(DW-15){1'b0}}, ir_q[14:0]};

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    a_d         = a_q;
    d_d         = d_q;
    ir_d        = ir_q;
    mr_d        = mr_q;
    wa_d        = wa_q;
    wd_d        = wd_q;
    imem_req_w  = 1'b0;
    dmem_req_w  = 1'b0;
    dmem_we_w   = 1'b0;
    dmem_addr_w = '0;
    retire_w    = 1'b0;

    case (state_q)
      S_FETCH: begin
        imem_req_w = 1'b1;
        if (imem_ack) begin
          ir_d    = imem_rdata;
          state_d = (imem_rdata[15] && imem_rdata[12]) ? S_DLOAD : S_EXEC;
        end
      end

      S_DLOAD: begin
        dmem_req_w  = 1'b1;
        dmem_addr_w = a_q[AW-1:0];
        if (dmem_ack) begin
          mr_d    = dmem_rdata;
          state_d = S_EXEC;
        end
      end

      S_EXEC: begin
        state_d = S_FETCH;
        if (!ir_q[15]) begin
          a_d      = a_imm;
          pc_d     = pc_inc;
          retire_w = 1'b1;
        end else begin
          // jump target and store address both use A before this instruction writes it
          pc_d = jump ? a_q[AW-1:0] : pc_inc;
          if (ir_q[5]) a_d = alu_out;
          if (ir_q[4]) d_d = alu_out;
          if (ir_q[3]) begin
            wa_d    = a_q[AW-1:0];
            wd_d    = alu_out;
            state_d = S_STORE;
          end else begin
            retire_w = 1'b1;
          end
        end
      end

      S_STORE: begin
        dmem_req_w  = 1'b1;
        dmem_we_w   = 1'b1;
        dmem_addr_w = wa_q;
        if (dmem_ack) begin
          retire_w = 1'b1;
          state_d  = S_FETCH;
        end
      end

      default: state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= S_FETCH;
      pc_q    <= AW'(RESET_PC);
      a_q     <= '0;
      d_q     <= '0;
      ir_q    <= '0;
      mr_q    <= '0;
      wa_q    <= '0;
      wd_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      a_q     <= a_d;
      d_q     <= d_d;
      ir_q    <= ir_d;
      mr_q    <= mr_d;
      wa_q    <= wa_d;
      wd_q    <= wd_d;
    end
  end

  // requests drop combinationally in the reset cycle so an open transfer is abandoned
  assign imem_req   = rstn & imem_req_w;
  assign imem_addr  = pc_q;
  assign dmem_req   = rstn & dmem_req_w;
  assign dmem_we    = rstn & dmem_we_w;
  assign dmem_addr  = dmem_addr_w;
  assign dmem_wdata = wd_q;
  assign pc         = pc_q;
  assign retire     = rstn & retire_w;

`ifdef HACK_CPU_INSTRET_EN
  logic [31:0] instret_q, instret_d;

  always_comb begin
    instret_d = instret_q;
    if (retire_w) instret_d = instret_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      instret_q <= '0;
    end else begin
      instret_q <= instret_d;
    end
  end

  assign instret = instret_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_hack_cpu_mc.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_hack_cpu_mc : scoreboard bench for hack_cpu_mc (DW=32) with an ISA model |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
module tb_hack_cpu_mc;
  localparam int DW     = 32;
  localparam int AW     = 15;
  localparam int MEMSZ  = 1 << AW;
  localparam int N_RAND = 300;
  localparam int EV_FETCH = 0, EV_READ = 1, EV_WRITE = 2, EV_RETIRE = 3;

  typedef struct {
    int            kind;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } ev_t;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          imem_req;
  logic [AW-1:0] imem_addr;
  logic          imem_ack;
  logic [15:0]   imem_rdata;
  logic          dmem_req;
  logic          dmem_we;
  logic [AW-1:0] dmem_addr;
  logic [DW-1:0] dmem_wdata;
  logic          dmem_ack;
  logic [DW-1:0] dmem_rdata;
  logic [AW-1:0] pc;
  logic          retire;
`ifdef HACK_CPU_INSTRET_EN
  logic [31:0]   instret;
`endif

  hack_cpu_mc #(.DW(DW), .AW(AW), .RESET_PC(0)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .imem_req  (imem_req),
    .imem_addr (imem_addr),
    .imem_ack  (imem_ack),
    .imem_rdata(imem_rdata),
    .dmem_req  (dmem_req),
    .dmem_we   (dmem_we),
    .dmem_addr (dmem_addr),
    .dmem_wdata(dmem_wdata),
    .dmem_ack  (dmem_ack),
    .dmem_rdata(dmem_rdata),
    .pc        (pc),
    .retire    (retire)
`ifdef HACK_CPU_INSTRET_EN
    ,
    .instret   (instret)
`endif
  );

  always #5 clk = ~clk;

  logic [15:0]   imem      [MEMSZ];
  logic [DW-1:0] resp_dmem [MEMSZ];
  logic [DW-1:0] m_dmem    [MEMSZ];
  logic [AW-1:0] m_pc;
  logic [DW-1:0] m_a, m_d;

  ev_t exp_q[$];
  int  errors = 0;
  int  checks = 0;
  int  retired = 0;
  int  target = 0;
  bit  hold_wr = 1'b0;
  bit  stray_dack = 1'b0;

  task automatic check(string name, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  function automatic void push(int k, logic [AW-1:0] a, logic [DW-1:0] d);
    ev_t e;
    e.kind = k;
    e.addr = a;
    e.data = d;
    exp_q.push_back(e);
  endfunction

  // ISA-level reference: executes one instruction and queues the bus events it must cause
  task automatic model_step();
    logic [15:0]   ins;
    logic [DW-1:0] x, y, o, old_a;
    logic          j;
    ins = imem[m_pc];
    push(EV_FETCH, m_pc, '0);
    if (!ins[15]) begin
      m_a  = DW'(ins[14:0]);
      m_pc = m_pc + AW'(1);
    end else begin
      old_a = m_a;
      if (ins[12]) begin
        push(EV_READ, old_a[AW-1:0], '0);
        y = m_dmem[old_a[AW-1:0]];
      end else begin
        y = old_a;
      end
      x = m_d;
      if (ins[11]) x = '0;
      if (ins[10]) x = ~x;
      if (ins[9])  y = '0;
      if (ins[8])  y = ~y;
      o = ins[7] ? x + y : x & y;
      if (ins[6])  o = ~o;
      j = (ins[2] && $signed(o) < 0) || (ins[1] && o == '0) || (ins[0] && $signed(o) > 0);
      m_pc = j ? old_a[AW-1:0] : m_pc + AW'(1);
      if (ins[5]) m_a = o;
      if (ins[4]) m_d = o;
      if (ins[3]) begin
        push(EV_WRITE, old_a[AW-1:0], o);
        m_dmem[old_a[AW-1:0]] = o;
      end
    end
    push(EV_RETIRE, '0, '0);
  endtask

  task automatic model_run(int n);
    m_pc = '0;
    m_a  = '0;
    m_d  = '0;
    for (int i = 0; i < n; i++) model_step();
  endtask

  function automatic logic [15:0] rand_ins();
    logic [15:0] w;
    w = 16'($urandom());
    if (w[15] && $urandom_range(0, 3) != 0) w[14:13] = 2'b11;
    return w;
  endfunction

  function automatic int pick_wait();
    int r;
    r = $urandom_range(0, 5);
    return (r > 3) ? 0 : r;
  endfunction

  task automatic expect_ev(string name, int kind, logic [AW-1:0] addr, logic [DW-1:0] data);
    ev_t e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s: got unexpected event addr=%0h data=%0h, expected none", name, addr, data);
      return;
    end
    e = exp_q.pop_front();
    if (e.kind != kind || e.addr !== addr || e.data !== data) begin
      errors++;
      $display("FAIL %s: got kind=%0d addr=%0h data=%0h, expected kind=%0d addr=%0h data=%0h",
               name, kind, addr, data, e.kind, e.addr, e.data);
    end
  endtask

  // memory responder with random wait states, driven on the falling edge
  initial begin
    int iwait, dwait;
    iwait = -1;
    dwait = -1;
    imem_ack = 1'b0; imem_rdata = '0;
    dmem_ack = 1'b0; dmem_rdata = '0;
    forever begin
      @(negedge clk);
      if (imem_ack) imem_ack = 1'b0;
      else if (imem_req) begin
        if (iwait < 0) iwait = pick_wait();
        if (iwait == 0) begin
          imem_ack   = 1'b1;
          imem_rdata = imem[imem_addr];
          iwait      = -1;
        end else iwait--;
      end else iwait = -1;

      if (stray_dack) begin
        dmem_ack = 1'b1;
        dwait    = -1;
      end else if (dmem_ack) dmem_ack = 1'b0;
      else if (dmem_req && !(dmem_we && hold_wr)) begin
        if (dwait < 0) dwait = pick_wait();
        if (dwait == 0) begin
          dmem_ack = 1'b1;
          if (dmem_we) resp_dmem[dmem_addr] = dmem_wdata;
          else         dmem_rdata = resp_dmem[dmem_addr];
          dwait = -1;
        end else dwait--;
      end else dwait = -1;
    end
  end

  // monitor: handshakes and retire pulses are popped against the model queue
  initial begin
    logic          p_ireq, p_iack, p_dreq, p_dack, p_dwe;
    logic [AW-1:0] p_iaddr, p_daddr;
    logic [DW-1:0] p_wdata;
    int            since_reset;
    p_ireq = 0; p_iack = 0; p_dreq = 0; p_dack = 0; p_dwe = 0;
    p_iaddr = '0; p_daddr = '0; p_wdata = '0;
    since_reset = 0;
    forever begin
      @(negedge clk);
      #2;
      if (!rstn) begin
        p_ireq = 0; p_dreq = 0; since_reset = 0;
        continue;
      end
      check("port_exclusive", 64'(imem_req && dmem_req), 64'd0);
      if (p_ireq && !p_iack) begin
        check("imem_req_held", 64'(imem_req), 64'd1);
        check("imem_addr_stable", 64'(imem_addr), 64'(p_iaddr));
      end
      if (p_dreq && !p_dack) begin
        check("dmem_req_held", 64'(dmem_req), 64'd1);
        check("dmem_addr_stable", 64'(dmem_addr), 64'(p_daddr));
        check("dmem_we_stable", 64'(dmem_we), 64'(p_dwe));
        if (p_dwe) check("dmem_wdata_stable", 64'(dmem_wdata), 64'(p_wdata));
      end
      if (retired < target) begin
        if (imem_req && imem_ack) expect_ev("fetch", EV_FETCH, imem_addr, '0);
        if (dmem_req && dmem_ack && !dmem_we) expect_ev("dread", EV_READ, dmem_addr, '0);
        if (dmem_req && dmem_ack && dmem_we) expect_ev("dwrite", EV_WRITE, dmem_addr, dmem_wdata);
        if (retire) begin
          expect_ev("retire", EV_RETIRE, '0, '0);
`ifdef HACK_CPU_INSTRET_EN
          check("instret", 64'(instret), 64'(since_reset));
`endif
          retired++;
        end
      end
      if (retire) since_reset++;
      p_ireq = imem_req; p_iack = imem_ack; p_iaddr = imem_addr;
      p_dreq = dmem_req; p_dack = dmem_ack; p_daddr = dmem_addr;
      p_dwe = dmem_we; p_wdata = dmem_wdata;
    end
  end

  task automatic wait_phase(string name, int limit);
    int n;
    n = 0;
    while (retired < target && n < limit) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (retired < target) begin
      errors++;
      $display("FAIL %s: got %0d retires, expected %0d before timeout", name, retired, target);
      target = retired;
    end
    @(negedge clk);
    check({name, "_drained"}, 64'(exp_q.size()), 64'd0);
    exp_q.delete();
  endtask

  initial begin
    int n;
    for (int i = 0; i < MEMSZ; i++) begin
      imem[i]      = rand_ins();
      resp_dmem[i] = DW'($urandom());
      m_dmem[i]    = resp_dmem[i];
    end
    imem[0]  = 16'h0015;  // @21
    imem[1]  = 16'hFDD8;  // MD=M+1
    imem[2]  = 16'hEA90;  // D=0
    imem[3]  = 16'h0005;  // @5
    imem[4]  = 16'hE302;  // D;JEQ  (taken)
    imem[5]  = 16'hEFD0;  // D=1
    imem[6]  = 16'h0009;  // @9
    imem[7]  = 16'hE302;  // D;JEQ  (not taken)
    imem[8]  = 16'hEE90;  // D=-1
    imem[9]  = 16'h0014;  // @20
    imem[10] = 16'hE304;  // D;JLT  (taken)
    imem[20] = 16'h0064;  // @100
    imem[21] = 16'hE308;  // M=D
    resp_dmem[21] = DW'(41);
    m_dmem[21]    = DW'(41);

    model_run(N_RAND);
    target = N_RAND;

    rstn = 1'b0;
    repeat (2) begin
      @(negedge clk);
      #2;
      check("rst_imem_req", 64'(imem_req), 64'd0);
      check("rst_dmem_req", 64'(dmem_req), 64'd0);
      check("rst_retire", 64'(retire), 64'd0);
    end
    check("rst_pc", 64'(pc), 64'd0);
    @(negedge clk);
    #1 rstn = 1'b1;
    #1;
    check("first_imem_req", 64'(imem_req), 64'd1);
    check("first_imem_addr", 64'(imem_addr), 64'd0);
    check("first_dmem_req", 64'(dmem_req), 64'd0);
    wait_phase("random_run", 20000);

    // store then reset while the write is stalled
    @(negedge clk);
    #1 rstn = 1'b0;
    hold_wr = 1'b1;
    imem[0] = 16'h0007;   // @7
    imem[1] = 16'hEFC8;   // M=1
    repeat (2) @(negedge clk);
    model_run(2);
    target = retired + 2;
    #1 rstn = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      #2;
      n++;
    end while (!(dmem_req && dmem_we) && n < 200);
    check("store_reached", 64'(dmem_req && dmem_we), 64'd1);
    repeat (2) begin
      @(negedge clk);
      #2;
      check("store_held_req", 64'(dmem_req), 64'd1);
      check("store_held_addr", 64'(dmem_addr), 64'd7);
      check("store_held_data", 64'(dmem_wdata), 64'd1);
    end
    @(negedge clk);
    #1 rstn = 1'b0;
    stray_dack = 1'b1;
    target = retired;
    exp_q.delete();
    #1;
    check("midstore_dmem_req", 64'(dmem_req), 64'd0);
    check("midstore_imem_req", 64'(imem_req), 64'd0);
    check("midstore_retire", 64'(retire), 64'd0);
    @(negedge clk);
    @(negedge clk);
    model_run(2);
    target = retired + 2;
    hold_wr = 1'b0;
    #1 rstn = 1'b1;
    #1;
    check("post_rst_pc", 64'(pc), 64'd0);
    check("post_rst_imem_req", 64'(imem_req), 64'd1);
    check("post_rst_imem_addr", 64'(imem_addr), 64'd0);
    @(negedge clk);
    #1 stray_dack = 1'b0;
    wait_phase("post_reset_run", 200);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
